// File: rtl/serial_arith_defs.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_defs;

  // FSM encodings; the unused 2'd3 pattern is steered back to StIdle by the FSMs.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: diff = a - b, borrow set when a < b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor
  import serial_arith_defs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
  logic             br_q, borrow_q;
  logic [CntW-1:0]  cnt_q;

  logic             hs0_diff, hs0_borrow;
  logic             bit_diff, hs1_borrow;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Full-subtractor cell from two half subtractors; the OR merges both borrow sources.
  half_subtractor u_hs0 (
    .a      (sa_q[0]),
    .b      (sb_q[0]),
    .diff   (hs0_diff),
    .borrow (hs0_borrow)
  );

  half_subtractor u_hs1 (
    .a      (hs0_diff),
    .b      (br_q),
    .diff   (bit_diff),
    .borrow (hs1_borrow)
  );

  assign br_next  = hs0_borrow | hs1_borrow;
  assign res_next = {bit_diff, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == LastCnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in StIdle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand/result shifters, borrow flop and bit counter; diff/borrow load on entry to StDone.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            sa_q  <= a;
            sb_q  <= b;
            br_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_next;
          res_q <= res_next;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            diff_q   <= res_next;
            borrow_q <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
